// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter sequencer with a run/halt handshake.
// It picks the next fetch address each cycle (sequential, relative branch,
// absolute jump or hold) and counts retired instructions with saturation.
module pc_fetch_ctrl #(
  parameter int D  = 9,
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [D-1:0]  startAddr_i,
  input  logic          stall_i,
  input  logic          branchTaken_i,
  input  logic [D-1:0]  target_i,
  input  logic          jumpAbs_i,
  input  logic [D-1:0]  jumpAddr_i,
  input  logic          halt_i,
  output logic [D-1:0]  progCtr_o,
  output logic          running_o,
  output logic          done_o,
  output logic [CW-1:0] instCount_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic [CW-1:0] countInc;

  // The retired counter sticks at all-ones instead of wrapping back to zero.
  always_comb begin
    countInc = (count_q == {CW{1'b1}}) ? count_q : count_q + {{(CW-1){1'b0}}, 1'b1};
  end

  // Next-state selection: Start only matters outside RUN; inside RUN the
  // priority is Halt, Stall, JumpAbs, BranchTaken, then sequential advance.
  // Target is a two's-complement offset, so a plain D-bit add with the carry
  // dropped gives both forward and backward branches.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    running_d = running_q;
    done_d    = done_q;
    case (state_q)
      IDLE, HALTED: begin
        if (start_i) begin
          state_d   = RUN;
          pc_d      = startAddr_i;
          count_d   = '0;
          running_d = 1'b1;
          done_d    = 1'b0;
        end
      end
      RUN: begin
        if (halt_i) begin
          state_d   = HALTED;
          count_d   = countInc;
          running_d = 1'b0;
          done_d    = 1'b1;
        end else if (!stall_i) begin
          count_d = countInc;
          if (jumpAbs_i) begin
            pc_d = jumpAddr_i;
          end else if (branchTaken_i) begin
            pc_d = pc_q + target_i;
          end else begin
            pc_d = pc_q + {{(D-1){1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        state_d   = IDLE;
        running_d = 1'b0;
        done_d    = 1'b0;
      end
    endcase
  end

  // All state and all outputs live in flops, so nothing combinational reaches
  // the ports; reset clears everything at once, even in the middle of a run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign progCtr_o   = pc_q;
  assign running_o   = running_q;
  assign done_o      = done_q;
  assign instCount_o = count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: scoreboard bench for pc_fetch_ctrl. A driver applies
// directed and random stimulus, predicts the response with an abstract
// model and queues it; a monitor pops and compares after each clock edge.
module tb_pc_fetch_ctrl;

  localparam int D      = 9;
  localparam int CW     = 16;
  localparam int PC_MOD = 512;
  localparam int CNT_MAX = 65535;

  typedef struct {
    int    pc;
    bit    run;
    bit    done;
    int    cnt;
    string tag;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start, stall, branchTaken, jumpAbs, halt;
  logic [D-1:0]  startAddr, target, jumpAddr;
  logic [D-1:0]  progCtr;
  logic          running, done;
  logic [CW-1:0] instCount;

  logic          start4;
  logic [D-1:0]  progCtr4;
  logic          running4, done4;
  logic [3:0]    instCount4;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  int   mPc;
  int   mCnt;
  bit   mRun;
  bit   mDone;

  pc_fetch_ctrl #(.D(D), .CW(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .startAddr_i(startAddr),
    .stall_i(stall), .branchTaken_i(branchTaken), .target_i(target),
    .jumpAbs_i(jumpAbs), .jumpAddr_i(jumpAddr), .halt_i(halt),
    .progCtr_o(progCtr), .running_o(running), .done_o(done),
    .instCount_o(instCount)
  );

  pc_fetch_ctrl #(.D(D), .CW(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .startAddr_i(9'd0),
    .stall_i(1'b0), .branchTaken_i(1'b0), .target_i(9'd0),
    .jumpAbs_i(1'b0), .jumpAddr_i(9'd0), .halt_i(1'b0),
    .progCtr_o(progCtr4), .running_o(running4), .done_o(done4),
    .instCount_o(instCount4)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single value comparison with a FAIL line on mismatch.
  task automatic checkValue(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Compare one predicted record against the live DUT outputs.
  task automatic checkOutput(input exp_t e);
    checkValue({e.tag, ".pc"},      int'(progCtr),   e.pc);
    checkValue({e.tag, ".running"}, int'(running),   int'(e.run));
    checkValue({e.tag, ".done"},    int'(done),      int'(e.done));
    checkValue({e.tag, ".count"},   int'(instCount), e.cnt);
  endtask

  task automatic modelReset();
    mPc = 0; mCnt = 0; mRun = 0; mDone = 0;
  endtask

  // Drive one cycle of inputs, advance the reference model and queue its
  // prediction for the monitor to check after the coming rising edge.
  task automatic applyStimulus(input bit st, input int sa, input bit stl,
                               input bit br, input int tgt, input bit jmp,
                               input int ja, input bit hlt, input string tag);
    exp_t e;
    int   offset;
    @(negedge clk);
    start = st; startAddr = D'(sa); stall = stl; branchTaken = br;
    target = D'(tgt); jumpAbs = jmp; jumpAddr = D'(ja); halt = hlt;
    if (!mRun) begin
      if (st) begin
        mPc = sa % PC_MOD; mCnt = 0; mRun = 1; mDone = 0;
      end
    end else if (hlt) begin
      mCnt = (mCnt < CNT_MAX) ? mCnt + 1 : CNT_MAX;
      mRun = 0; mDone = 1;
    end else if (!stl) begin
      mCnt = (mCnt < CNT_MAX) ? mCnt + 1 : CNT_MAX;
      if (jmp) begin
        mPc = ja % PC_MOD;
      end else if (br) begin
        offset = (tgt % PC_MOD >= PC_MOD / 2) ? (tgt % PC_MOD) - PC_MOD : tgt % PC_MOD;
        mPc = ((mPc + offset) % PC_MOD + PC_MOD) % PC_MOD;
      end else begin
        mPc = (mPc + 1) % PC_MOD;
      end
    end
    e.pc = mPc; e.run = mRun; e.done = mDone; e.cnt = mCnt; e.tag = tag;
    expQ.push_back(e);
  endtask

  // Monitor: one registered response per rising edge, sampled just after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    int wait_cycles;
    start = 0; startAddr = 0; stall = 0; branchTaken = 0; target = 0;
    jumpAbs = 0; jumpAddr = 0; halt = 0; start4 = 0;
    modelReset();

    // Test 1: reset held with random inputs keeps everything at zero.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'($urandom); startAddr = D'($urandom); stall = 1'($urandom);
      branchTaken = 1'($urandom); target = D'($urandom); jumpAbs = 1'($urandom);
      jumpAddr = D'($urandom); halt = 1'($urandom);
      @(posedge clk); #1;
      checkValue("rst.pc", int'(progCtr), 0);
      checkValue("rst.running", int'(running), 0);
      checkValue("rst.done", int'(done), 0);
      checkValue("rst.count", int'(instCount), 0);
    end
    @(negedge clk);
    start = 0; stall = 0; branchTaken = 0; jumpAbs = 0; halt = 0;
    rst_n = 1'b1;
    applyStimulus(1, 4, 0, 0, 0, 0, 0, 0, "t1.start");

    // Test 2: negative, positive and zero branch offsets.
    applyStimulus(0, 0, 0, 1, 9'h1FB, 0, 0, 0, "t2.brNeg");
    applyStimulus(0, 0, 0, 1, 20, 0, 0, 0, "t2.brPos");
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, "t2.brZero");

    // Test 3: sequential wrap at the top, then jump beats branch.
    applyStimulus(0, 0, 0, 0, 0, 1, 9'h1FF, 0, "t3.jmpTop");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "t3.wrap");
    applyStimulus(0, 0, 0, 1, 7, 1, 100, 0, "t3.jmpWins");

    // Test 4: stall freezes, halt beats stall.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 33, 0, 0, 0, "t4.stall");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, "t4.haltStall");
    applyStimulus(0, 0, 0, 1, 5, 1, 9, 0, "t4.haltedIgnore");

    // Test 5: restart from HALTED, then Start during RUN is ignored.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "t5.restart");
    applyStimulus(1, 77, 0, 0, 0, 0, 0, 0, "t5.startInRun");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "t5.seq");

    // Random mix of every control combination.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) == 0, int'($urandom_range(0, 511)),
                    $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                    int'($urandom_range(0, 511)), $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, 511)), $urandom_range(0, 19) == 0,
                    "rand");
    end

    // Test 6: async reset in the middle of a run at PC=50.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, "t6.halt");
    applyStimulus(1, 50, 0, 0, 0, 0, 0, 0, "t6.start50");
    @(posedge clk); #2;
    checkValue("t6.preReset.pc", int'(progCtr), 50);
    rst_n = 1'b0;
    #1;
    expQ.delete();
    modelReset();
    checkValue("t6.async.pc", int'(progCtr), 0);
    checkValue("t6.async.running", int'(running), 0);
    checkValue("t6.async.done", int'(done), 0);
    checkValue("t6.async.count", int'(instCount), 0);
    @(negedge clk);
    start = 0; halt = 0; stall = 0; branchTaken = 0; jumpAbs = 0;
    rst_n = 1'b1;

    // Narrow counter: 20 retired instructions saturate a 4-bit count at 15.
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (19) @(negedge clk);
    @(posedge clk); #1;
    checkValue("t6.cw4.count", int'(instCount4), 15);
    checkValue("t6.cw4.running", int'(running4), 1);
    checkValue("t6.cw4.pc", int'(progCtr4), 20);

    // Drain the scoreboard with a bounded wait.
    wait_cycles = 0;
    while (expQ.size() > 0 && wait_cycles < 5) begin
      @(posedge clk); #2;
      wait_cycles++;
    end
    checkValue("drain.queueLeft", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
